// File: rtl/mod12_step_arbiter.sv
// Shared mod-MOD up/down step counter, round-robin arbitrated between two
// requesters; moves are stepped one position per clock.
module mod12_step_arbiter #(
  parameter int MOD = 12,
  parameter int CW  = 4,
  parameter int SW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic          a_up,
  input  logic [SW-1:0] a_steps,
  output logic          a_ready,
  output logic          a_done,
  input  logic          b_valid,
  input  logic          b_up,
  input  logic [SW-1:0] b_steps,
  output logic          b_ready,
  output logic          b_done,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          owner,
  output logic          wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] TOP = CW'(MOD - 1);

  state_t        state, state_nx;
  logic          last_owner;
  logic          dir;
  logic [SW-1:0] rem;

  logic          sel_b;
  logic          accept;
  logic          cap_up;
  logic [SW-1:0] cap_steps;
  logic [CW-1:0] count_nx;
  logic          at_edge;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    sel_b     = b_valid && (!a_valid || !last_owner);
    a_ready   = (state == IDLE) && a_valid && !sel_b;
    b_ready   = (state == IDLE) && sel_b;
    accept    = a_ready || b_ready;
    cap_up    = sel_b ? b_up : a_up;
    cap_steps = sel_b ? b_steps : a_steps;
  end

  always_comb begin
    if (dir) begin
      at_edge  = (count == TOP);
      count_nx = at_edge ? '0 : count + CW'(1);
    end else begin
      at_edge  = (count == '0);
      count_nx = at_edge ? TOP : count - CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (cap_steps == '0) ? DONE : RUN;
      RUN:  if (rem == SW'(1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      owner      <= 1'b1;
      last_owner <= 1'b1;
      dir        <= 1'b0;
      rem        <= '0;
      wrap       <= 1'b0;
    end else begin
      state <= state_nx;
      wrap  <= 1'b0;
      if (accept) begin
        dir   <= cap_up;
        rem   <= cap_steps;
        owner <= sel_b;
      end
      if (state == RUN) begin
        count <= count_nx;
        rem   <= rem - SW'(1);
        wrap  <= at_edge;
      end
      if (state == DONE)
        last_owner <= owner;
    end
  end

  assign busy   = (state != IDLE);
  assign a_done = (state == DONE) && !owner;
  assign b_done = (state == DONE) && owner;

endmodule

// File: tb/tb_mod12_step_arbiter.sv
// Bench for mod12_step_arbiter: scripted scenarios then random traffic,
// checked against a transaction-level trajectory model.
module tb_mod12_step_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_up, b_valid, b_up;
  logic [3:0] a_steps, b_steps;
  logic       a_ready, a_done, b_ready, b_done;
  logic [3:0] count;
  logic       busy, owner, wrap;

  mod12_step_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_up(a_up), .a_steps(a_steps),
    .a_ready(a_ready), .a_done(a_done),
    .b_valid(b_valid), .b_up(b_up), .b_steps(b_steps),
    .b_ready(b_ready), .b_done(b_done),
    .count(count), .busy(busy), .owner(owner), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit wr;
    bit done;
  } exp_t;

  exp_t q[$];
  int   m_count;
  bit   m_owner, m_last;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, obs, exp, $time);
  endtask

  function automatic int pos(input int c0, input bit up, input int k);
    int v;
    v = up ? c0 + k : c0 - k;
    return ((v % 12) + 12) % 12;
  endfunction

  task automatic model_reset();
    q.delete();
    m_count = 0;
    m_owner = 1'b1;
    m_last  = 1'b1;
  endtask

  task automatic cyc(input bit rst,
                     input bit av, input bit aup, input int as,
                     input bit bv, input bit bup, input int bs);
    exp_t e;
    bit   ga, gb, up;
    int   n, prev;
    reset   = rst;
    a_valid = av; a_up = aup; a_steps = 4'(as);
    b_valid = bv; b_up = bup; b_steps = 4'(bs);
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count", 32'(count), 32'(e.cnt));
      chk("wrap", 32'(wrap), 32'(e.wr));
      chk("busy", 32'(busy), 32'd1);
      chk("a_done", 32'(a_done), 32'(e.done && !m_owner));
      chk("b_done", 32'(b_done), 32'(e.done && m_owner));
      chk("ready_busy", 32'({a_ready, b_ready}), 32'd0);
      chk("owner", 32'(owner), 32'(m_owner));
      if (e.done) m_last = m_owner;
    end else begin
      gb = bv && (!av || !m_last);
      ga = av && !gb;
      chk("idle_count", 32'(count), 32'(m_count));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wrap", 32'(wrap), 32'd0);
      chk("idle_done", 32'({a_done, b_done}), 32'd0);
      chk("idle_owner", 32'(owner), 32'(m_owner));
      chk("a_ready", 32'(a_ready), 32'(ga));
      chk("b_ready", 32'(b_ready), 32'(gb));
      if ((ga || gb) && !rst) begin
        m_owner = gb;
        up = gb ? bup : aup;
        n  = gb ? bs : as;
        for (int k = 0; k <= n; k++) begin
          prev  = pos(m_count, up, k - 1);
          e.cnt = pos(m_count, up, k);
          e.wr  = (k > 0) && (up ? prev == 11 : prev == 0);
          e.done = (k == n);
          q.push_back(e);
        end
        m_count = pos(m_count, up, n);
      end
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_up = 1'b0; a_steps = '0;
    b_valid = 1'b0; b_up = 1'b0; b_steps = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    cyc(0, 1, 1, 3, 0, 0, 0);
    idle(6);

    rst_cyc();
    cyc(0, 0, 0, 0, 1, 0, 2);
    idle(5);

    rst_cyc();
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 1, 1, 0, 1);
    idle(2);

    cyc(0, 1, 1, 0, 0, 0, 0);
    idle(3);

    rst_cyc();
    cyc(0, 1, 1, 5, 0, 0, 0);
    idle(7);
    cyc(0, 1, 1, 13, 0, 0, 0);
    idle(16);

    rst_cyc();
    cyc(0, 0, 0, 0, 1, 0, 5);
    idle(2);
    rst_cyc();
    idle(2);
    cyc(0, 1, 1, 2, 1, 1, 2);
    idle(6);

    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 9) < 4), 1'($urandom), $urandom_range(0, 15),
          ($urandom_range(0, 9) < 4), 1'($urandom), $urandom_range(0, 15));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
